// File: rtl/prbs_pkg.sv
// prbs_pkg -- shared definitions for the PRBS pattern generator.
//   state_t        : generator FSM states (IDLE, PRIME, RUN)
//   WORD_W         : output word width (32 sequence bits per word)
//   LFSR_W         : LFSR register width (sized for PRBS-31; PRBS-7 uses the low 7 bits)
//   P31_* / P7_*   : polynomial lengths and feedback tap positions
//   DEF_SEED31/7   : default LFSR load values (must be non-zero)
package prbs_pkg;

  localparam int WORD_W = 32;
  localparam int LFSR_W = 31;

  // x^31 + x^28 + 1 : feedback from state bits 30 and 27
  localparam int P31_LEN   = 31;
  localparam int P31_TAP_A = 30;
  localparam int P31_TAP_B = 27;

  // x^7 + x^6 + 1 : feedback from state bits 6 and 5
  localparam int P7_LEN   = 7;
  localparam int P7_TAP_A = 6;
  localparam int P7_TAP_B = 5;

  localparam logic [P31_LEN-1:0] DEF_SEED31 = 31'h7FFFFFFF;
  localparam logic [P7_LEN-1:0]  DEF_SEED7  = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  // An LFSR locked at zero never leaves it; only the active polynomial's
  // bits matter (PRBS-7 leaves stale history in the upper bits).
  function automatic logic lfsr_is_zero(input logic [LFSR_W-1:0] s, input logic sel31);
    return sel31 ? (s == '0) : (s[P7_LEN-1:0] == '0);
  endfunction

endpackage

// File: rtl/prbs_lfsr32.sv
// prbs_lfsr32 -- combinational 32-step advance of a Fibonacci LFSR.
//   state      : current LFSR state (s[0] is the most recently generated bit)
//   sel31      : 1 = PRBS-31 (x^31+x^28+1), 0 = PRBS-7 (x^7+x^6+1)
//   next_state : state after 32 steps
//   word       : the 32 generated bits, first bit in time at word[31]
module prbs_lfsr32
  import prbs_pkg::*;
(
  input  logic [LFSR_W-1:0] state,
  input  logic              sel31,
  output logic [LFSR_W-1:0] next_state,
  output logic [WORD_W-1:0] word
);

  // st[i] is the state after i single-bit steps.
  logic [WORD_W:0][LFSR_W-1:0] st;

  assign st[0] = state;

  for (genvar i = 0; i < WORD_W; i++) begin : g_step
    logic fb;
    assign fb        = sel31 ? (st[i][P31_TAP_A] ^ st[i][P31_TAP_B])
                             : (st[i][P7_TAP_A]  ^ st[i][P7_TAP_B]);
    // In PRBS-7 mode the bits above 6 just carry old history and are never tapped.
    assign st[i+1]   = {st[i][LFSR_W-2:0], fb};
    assign word[WORD_W-1-i] = fb;
  end

  assign next_state = st[WORD_W];

endmodule

// File: rtl/prbs_pattern_gen.sv
// prbs_pattern_gen -- 32-bit-per-word PRBS-7 / PRBS-31 pattern source with
// ready/valid handshake, accepted-word counter and stuck-at-zero recovery.
//
// Optional feature macro: PRBS_ERR_INJECT_EN
//   defined   : err_inject_i arms a pending flag that flips bit 0 of the
//               presented word until that word is accepted.
//   undefined : err_inject_i is accepted but has no effect.
//
// Ports
//   tx_clk_i      in   clock, rising edge
//   reset_i       in   asynchronous active-high reset
//   start_gen_i   in   level go; low returns to IDLE on the next edge
//   prbs_sel_i    in   0 = PRBS-7, 1 = PRBS-31 (sampled in PRIME only)
//   tx_ready_i    in   downstream accepts the presented word
//   err_inject_i  in   single-cycle corrupt-one-word request
//   tx_data_o     out  [31:0] pattern word, bit 31 first in time
//   tx_valid_o    out  tx_data_o valid (RUN only)
//   word_count_o  out  [31:0] accepted words, saturating
//   lfsr_zero_o   out  sticky: an all-zero LFSR state was seen and reseeded
module prbs_pattern_gen
  import prbs_pkg::*;
#(
  parameter logic [P31_LEN-1:0] SEED31 = DEF_SEED31,
  parameter logic [P7_LEN-1:0]  SEED7  = DEF_SEED7
) (
  input  logic              tx_clk_i,
  input  logic              reset_i,
  input  logic              start_gen_i,
  input  logic              prbs_sel_i,
  input  logic              tx_ready_i,
  input  logic              err_inject_i,
  output logic [WORD_W-1:0] tx_data_o,
  output logic              tx_valid_o,
  output logic [WORD_W-1:0] word_count_o,
  output logic              lfsr_zero_o
);

  state_t              state;
  logic                sel_q;
  logic [LFSR_W-1:0]   lfsr_q;
  logic [WORD_W-1:0]   data_q;
  logic                valid_q;
  logic [WORD_W-1:0]   count_q;
  logic                zero_q;

  logic [LFSR_W-1:0]   adv_in;
  logic                adv_sel;
  logic [LFSR_W-1:0]   adv_next;
  logic [WORD_W-1:0]   adv_word;
  logic                accept;
  logic                lfsr_zero;

  function automatic logic [LFSR_W-1:0] seed_of(input logic sel31);
    return sel31 ? SEED31 : {{(LFSR_W-P7_LEN){1'b0}}, SEED7};
  endfunction

  // PRIME advances straight from the seed of the newly selected polynomial,
  // so the first word lands in the output register as RUN begins.
  assign adv_in  = (state == ST_PRIME) ? seed_of(prbs_sel_i) : lfsr_q;
  assign adv_sel = (state == ST_PRIME) ? prbs_sel_i : sel_q;

  prbs_lfsr32 u_lfsr (
    .state      (adv_in),
    .sel31      (adv_sel),
    .next_state (adv_next),
    .word       (adv_word)
  );

  // Dropping start wins over ready in the same cycle.
  assign accept    = valid_q & tx_ready_i & start_gen_i;
  assign lfsr_zero = lfsr_is_zero(lfsr_q, sel_q);

  always_ff @(posedge tx_clk_i or posedge reset_i) begin
    if (reset_i) begin
      state   <= ST_IDLE;
      sel_q   <= 1'b1;
      lfsr_q  <= SEED31;
      data_q  <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
      zero_q  <= 1'b0;
    end else begin
      if (!start_gen_i) begin
        state   <= ST_IDLE;
        valid_q <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            state <= ST_PRIME;
          end
          ST_PRIME: begin
            sel_q   <= prbs_sel_i;
            lfsr_q  <= adv_next;
            data_q  <= adv_word;
            count_q <= '0;
            valid_q <= 1'b1;
            state   <= ST_RUN;
          end
          ST_RUN: begin
            if (accept) begin
              lfsr_q  <= adv_next;
              data_q  <= adv_word;
              if (count_q != '1) count_q <= count_q + 1'b1;
            end
          end
          default: begin
            state   <= ST_IDLE;
            valid_q <= 1'b0;
          end
        endcase
      end
      // Stuck-at-zero recovery overrides any advance; PRIME reloads anyway.
      if (state != ST_PRIME && lfsr_zero) begin
        lfsr_q <= seed_of(sel_q);
        zero_q <= 1'b1;
      end
    end
  end

`ifdef PRBS_ERR_INJECT_EN
  logic inj_pend;

  // Pulses merge into one pending flag; it drops when the corrupted word
  // is taken. A pulse on the accepting cycle arms the following word.
  always_ff @(posedge tx_clk_i or posedge reset_i) begin
    if (reset_i) inj_pend <= 1'b0;
    else         inj_pend <= (inj_pend & ~accept) | err_inject_i;
  end

  // Corruption is applied on the way out so the LFSR sequence is untouched.
  assign tx_data_o = data_q ^ {{(WORD_W-1){1'b0}}, inj_pend & valid_q};
`else
  logic unused_inject;
  assign unused_inject = err_inject_i;
  assign tx_data_o     = data_q;
`endif

  assign tx_valid_o   = valid_q;
  assign word_count_o = count_q;
  assign lfsr_zero_o  = zero_q;

endmodule

// File: tb/tb_prbs_pattern_gen.sv
// tb_prbs_pattern_gen -- randomized self-checking bench for prbs_pattern_gen.
// The reference model produces the pattern from the bit recurrence
// x[n] = x[n-31]^x[n-28] (or x[n-7]^x[n-6]) over a history seeded from the
// load value, and tracks valid / count / inject from the handshake rules.
module tb_prbs_pattern_gen;

  localparam logic [30:0] S31 = 31'h7FFFFFFF;
  localparam logic [6:0]  S7  = 7'h7F;

  logic        tx_clk_i = 1'b0;
  logic        reset_i;
  logic        start_gen_i;
  logic        prbs_sel_i;
  logic        tx_ready_i;
  logic        err_inject_i;
  logic [31:0] tx_data_o;
  logic        tx_valid_o;
  logic [31:0] word_count_o;
  logic        lfsr_zero_o;

  int checks = 0;
  int errors = 0;

  prbs_pattern_gen dut (
    .tx_clk_i     (tx_clk_i),
    .reset_i      (reset_i),
    .start_gen_i  (start_gen_i),
    .prbs_sel_i   (prbs_sel_i),
    .tx_ready_i   (tx_ready_i),
    .err_inject_i (err_inject_i),
    .tx_data_o    (tx_data_o),
    .tx_valid_o   (tx_valid_o),
    .word_count_o (word_count_o),
    .lfsr_zero_o  (lfsr_zero_o)
  );

  always #5 tx_clk_i = ~tx_clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_phase;   // 0 idle, 1 prime, 2 run
  bit          m_sel;
  bit          hist[$];   // generated bit history, oldest first
  logic [31:0] e_data;
  logic [31:0] e_count;
  bit          e_valid;
  bit          e_pend;
  logic [31:0] acc_q[$];  // words the DUT handed over

  function automatic logic [31:0] gen_word();
    logic [31:0] w;
    int          len;
    bit          b;
    w = '0;
    for (int k = 0; k < 32; k++) begin
      len = hist.size();
      b = m_sel ? (hist[len-31] ^ hist[len-28]) : (hist[len-7] ^ hist[len-6]);
      hist.push_back(b);
      w = {w[30:0], b};
    end
    while (hist.size() > 40) void'(hist.pop_front());
    return w;
  endfunction

  function automatic void load_seed(input bit sel31);
    hist.delete();
    if (sel31) for (int i = 30; i >= 0; i--) hist.push_back(S31[i]);
    else       for (int i = 6;  i >= 0; i--) hist.push_back(S7[i]);
  endfunction

  function automatic logic [31:0] e_out();
    return e_data ^ {31'b0, e_pend & e_valid};
  endfunction

  always @(posedge tx_clk_i or posedge reset_i) begin
    bit acc;
    if (reset_i) begin
      m_phase = 0; m_sel = 1'b1; e_data = '0; e_count = '0; e_valid = 1'b0; e_pend = 1'b0;
    end else begin
      acc = e_valid && tx_ready_i && start_gen_i;
      if (tx_valid_o && tx_ready_i && start_gen_i) acc_q.push_back(tx_data_o);
`ifdef PRBS_ERR_INJECT_EN
      e_pend = (e_pend && !acc) || err_inject_i;
`endif
      if (!start_gen_i) begin
        m_phase = 0; e_valid = 1'b0;
      end else if (m_phase == 0) begin
        m_phase = 1;
      end else if (m_phase == 1) begin
        m_sel = prbs_sel_i;
        load_seed(m_sel);
        e_data = gen_word(); e_count = '0; e_valid = 1'b1; m_phase = 2;
      end else if (acc) begin
        if (e_count != 32'hFFFFFFFF) e_count = e_count + 1;
        e_data = gen_word();
      end
    end
  end

  // Per-cycle compare, 1 time unit after the active edge.
  always @(posedge tx_clk_i) begin
    #1;
    check("valid", {31'b0, tx_valid_o}, {31'b0, e_valid});
    check("data", tx_data_o, e_out());
    check("count", word_count_o, e_count);
    check("zero_flag", {31'b0, lfsr_zero_o}, 32'd0);
  end

  task automatic wait_valid(input string name, output int n);
    n = 0;
    while (!tx_valid_o && n < 50) begin
      @(negedge tx_clk_i);
      n++;
    end
    if (!tx_valid_o) begin
      checks++; errors++;
      $display("FAIL %s timeout waiting for tx_valid_o actual=0 expected=1", name);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          n;
    int          mism;
    bit          bits[$];
    logic [31:0] w;

    reset_i = 1'b1; start_gen_i = 1'b0; prbs_sel_i = 1'b1; tx_ready_i = 1'b0; err_inject_i = 1'b0;
    repeat (3) @(negedge tx_clk_i);
    check("rst_valid", {31'b0, tx_valid_o}, 32'd0);
    check("rst_data", tx_data_o, 32'd0);
    check("rst_count", word_count_o, 32'd0);
    reset_i = 1'b0;
    repeat (3) @(negedge tx_clk_i);
    check("idle_hold_valid", {31'b0, tx_valid_o}, 32'd0);

    // PRBS-31, always ready: latency, first word, 1000 words vs model
    prbs_sel_i = 1'b1; tx_ready_i = 1'b1; start_gen_i = 1'b1;
    wait_valid("p31_start", n);
    check("latency", n, 32'd2);
    check("p31_first_word", tx_data_o, 32'h0000000E);
    acc_q.delete();
    n = 0;
    while (acc_q.size() < 1000 && n < 1100) begin @(negedge tx_clk_i); n++; end
    check("p31_1000_words", acc_q.size() >= 1000, 32'd1);

    // start dropped with ready high: no acceptance, valid low next cycle
    start_gen_i = 1'b0;
    @(negedge tx_clk_i);
    check("drop_valid", {31'b0, tx_valid_o}, 32'd0);
    repeat (2) @(negedge tx_clk_i);
    start_gen_i = 1'b1;
    wait_valid("restart", n);
    check("restart_word", tx_data_o, 32'h0000000E);
    check("restart_count", word_count_o, 32'd0);

    // PRBS-7
    start_gen_i = 1'b0;
    @(negedge tx_clk_i);
    prbs_sel_i = 1'b0; start_gen_i = 1'b1; acc_q.delete();
    wait_valid("p7_start", n);
    w = tx_data_o;
    check("p7_top14", {18'b0, w[31:18]}, {18'b0, 14'b00000010000011});
    prbs_sel_i = 1'b1;  // ignored outside PRIME
    n = 0;
    while (acc_q.size() < 16 && n < 100) begin @(negedge tx_clk_i); n++; end
    bits.delete();
    foreach (acc_q[i]) for (int b = 31; b >= 0; b--) bits.push_back(acc_q[i][b]);
    mism = 0;
    for (int i = 0; i + 127 < bits.size(); i++) if (bits[i] != bits[i+127]) mism++;
    check("p7_period127", mism, 32'd0);
    check("p7_enough_bits", bits.size() >= 400, 32'd1);

    // randomized handshake, select, inject and occasional start drops
    for (int c = 0; c < 3000; c++) begin
      @(negedge tx_clk_i);
      tx_ready_i   = 1'($urandom_range(0, 1));
      start_gen_i  = ($urandom_range(0, 63) != 0);
      prbs_sel_i   = 1'($urandom_range(0, 1));
      err_inject_i = ($urandom_range(0, 15) == 0);
    end
    @(negedge tx_clk_i);
    err_inject_i = 1'b0;

    // directed inject during a stall
    start_gen_i = 1'b0; tx_ready_i = 1'b0;
    @(negedge tx_clk_i);
    prbs_sel_i = 1'b1; start_gen_i = 1'b1;
    wait_valid("inj_start", n);
    @(negedge tx_clk_i);
    err_inject_i = 1'b1;
    @(negedge tx_clk_i);
    err_inject_i = 1'b1;  // second pulse merges with the first
    @(negedge tx_clk_i);
    err_inject_i = 1'b0;
`ifdef PRBS_ERR_INJECT_EN
    check("inj_bit0", tx_data_o, 32'h0000000F);
`else
    check("inj_ignored", tx_data_o, 32'h0000000E);
`endif
    tx_ready_i = 1'b1;
    @(negedge tx_clk_i);
    tx_ready_i = 1'b0;
    check("after_inj", tx_data_o, e_data);
    check("after_inj_count", word_count_o, 32'd1);

    // asynchronous reset mid-RUN
    tx_ready_i = 1'b1;
    repeat (4) @(negedge tx_clk_i);
    @(posedge tx_clk_i);
    #3;
    reset_i = 1'b1;
    #1;
    check("async_valid", {31'b0, tx_valid_o}, 32'd0);
    check("async_data", tx_data_o, 32'd0);
    check("async_count", word_count_o, 32'd0);
    check("async_zero", {31'b0, lfsr_zero_o}, 32'd0);
    start_gen_i = 1'b0;
    @(negedge tx_clk_i);
    reset_i = 1'b0;
    repeat (3) @(negedge tx_clk_i);
    check("post_rst_idle", {31'b0, tx_valid_o}, 32'd0);
    start_gen_i = 1'b1;
    wait_valid("post_rst_start", n);
    check("post_rst_word", tx_data_o, 32'h0000000E);
    repeat (5) @(negedge tx_clk_i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
